// File: rtl/brick_damage_pkg.sv
// Shared game constants for the brick field.
// Holds brick geometry, grid size, health encoding, the damage FSM state type
// and the pending-hit record used by brick_damage.
package brick_damage_pkg;

  localparam int unsigned BRICKX      = 32;   // brick width in pixels (power of two)
  localparam int unsigned BRICKY      = 16;   // brick height in pixels (power of two)
  localparam int unsigned COLS        = 20;
  localparam int unsigned ROWS        = 8;
  localparam int unsigned BRICK_COUNT = COLS * ROWS;

  localparam logic [1:0] HEALTH_DEAD = 2'd0;
  localparam logic [1:0] HEALTH_FULL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_RD,
    ST_RDW,
    ST_WR,
    ST_DRAW
  } state_e;

  // One-entry pending hit per channel: target RAM address and brick origin.
  typedef struct packed {
    logic       valid;
    logic [7:0] addr;
    logic [9:0] bx;
    logic [9:0] by;
  } hit_t;

endpackage

// File: rtl/brick_damage_addr_map.sv
// brick_addr_map: combinational pixel-to-brick mapping for one hit channel.
// Ports:
//   x_i, y_i  - pixel probe point
//   valid_o   - probe lies inside the brick grid
//   addr_o    - row*COLS + col, truncated to 8 bits
//   bx_o,by_o - top-left pixel of the brick containing the probe
module brick_addr_map
  import brick_damage_pkg::*;
#(
  parameter int unsigned BRICKX = brick_damage_pkg::BRICKX,
  parameter int unsigned BRICKY = brick_damage_pkg::BRICKY,
  parameter int unsigned COLS   = brick_damage_pkg::COLS,
  parameter int unsigned ROWS   = brick_damage_pkg::ROWS
) (
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       valid_o,
  output logic [7:0] addr_o,
  output logic [9:0] bx_o,
  output logic [9:0] by_o
);

  localparam int unsigned XSH = $clog2(BRICKX);
  localparam int unsigned YSH = $clog2(BRICKY);

  logic [9:0] col;
  logic [9:0] row;

  always_comb begin
    col     = x_i >> XSH;
    row     = y_i >> YSH;
    valid_o = (32'(col) < COLS) && (32'(row) < ROWS);
    addr_o  = 8'(32'(row) * COLS + 32'(col));
    // Brick sizes are powers of two, so the origin is the probe with low bits cleared.
    bx_o    = x_i & ~10'(BRICKX - 1);
    by_o    = y_i & ~10'(BRICKY - 1);
  end

endmodule

// File: rtl/brick_damage.sv
// brick_damage: applies ball hits to the brick health RAM.
// Each of two hit channels feeds a one-entry pending register; an FSM picks a
// pending hit (channel 1 first), reads the brick health, writes back health-1,
// requests a redraw and tracks the number of live bricks.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   collided_1, col_x1, col_y1 - vertical-hit pulse and probe point
//   collided_2, col_x2, col_y2 - horizontal-hit pulse and probe point
//   mem_addr/mem_rdata/mem_wdata/mem_we - health RAM port (1-cycle read latency)
//   draw_req/draw_ack, draw_x/draw_y/draw_health - redraw handshake
//   score_inc    - pulse when a brick is destroyed
//   bricks_left  - live brick count; level_clear when it reaches 0
//   busy         - FSM not idle
//   drop_err     - sticky: a hit arrived while its channel was still pending
module brick_damage
  import brick_damage_pkg::*;
#(
  parameter int unsigned BRICKX = brick_damage_pkg::BRICKX,
  parameter int unsigned BRICKY = brick_damage_pkg::BRICKY,
  parameter int unsigned COLS   = brick_damage_pkg::COLS,
  parameter int unsigned ROWS   = brick_damage_pkg::ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       collided_1,
  input  logic [9:0] col_x1,
  input  logic [9:0] col_y1,
  input  logic       collided_2,
  input  logic [9:0] col_x2,
  input  logic [9:0] col_y2,
  output logic [7:0] mem_addr,
  input  logic [1:0] mem_rdata,
  output logic [1:0] mem_wdata,
  output logic       mem_we,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [9:0] draw_x,
  output logic [9:0] draw_y,
  output logic [1:0] draw_health,
  output logic       score_inc,
  output logic [7:0] bricks_left,
  output logic       level_clear,
  output logic       busy,
  output logic       drop_err
);

  localparam int unsigned LEFT_INIT = COLS * ROWS;

  logic       m1_valid, m2_valid;
  logic [7:0] m1_addr, m2_addr;
  logic [9:0] m1_bx, m1_by, m2_bx, m2_by;

  brick_addr_map #(.BRICKX(BRICKX), .BRICKY(BRICKY), .COLS(COLS), .ROWS(ROWS)) u_map1 (
    .x_i(col_x1), .y_i(col_y1), .valid_o(m1_valid), .addr_o(m1_addr), .bx_o(m1_bx), .by_o(m1_by)
  );

  brick_addr_map #(.BRICKX(BRICKX), .BRICKY(BRICKY), .COLS(COLS), .ROWS(ROWS)) u_map2 (
    .x_i(col_x2), .y_i(col_y2), .valid_o(m2_valid), .addr_o(m2_addr), .bx_o(m2_bx), .by_o(m2_by)
  );

  state_e     state_q, state_d;
  hit_t       p1_q, p1_d, p2_q, p2_d;
  logic       drop_q, drop_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [1:0] mem_wdata_q, mem_wdata_d;
  logic [9:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [9:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic [1:0] draw_health_q, draw_health_d;
  logic [7:0] left_q, left_d;

  logic clr1, clr2, cap1, cap2;

  // Pending registers. A register being released by SEL this cycle counts as free.
  always_comb begin
    p1_d   = p1_q;
    p2_d   = p2_q;
    drop_d = drop_q;
    clr1   = (state_q == ST_SEL) && p1_q.valid;
    clr2   = (state_q == ST_SEL) && !p1_q.valid && p2_q.valid;
    cap1   = collided_1 && m1_valid;
    // Same brick hit on both channels in one cycle: channel 1 alone takes it.
    cap2   = collided_2 && m2_valid && !(cap1 && (m1_addr == m2_addr));

    if (clr1) p1_d.valid = 1'b0;
    if (clr2) p2_d.valid = 1'b0;

    if (cap1) begin
      if (p1_q.valid && !clr1) drop_d = 1'b1;
      else                     p1_d   = '{valid: 1'b1, addr: m1_addr, bx: m1_bx, by: m1_by};
    end
    if (cap2) begin
      if (p2_q.valid && !clr2) drop_d = 1'b1;
      else                     p2_d   = '{valid: 1'b1, addr: m2_addr, bx: m2_bx, by: m2_by};
    end
  end

  // Damage FSM next state and datapath.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    draw_x_d      = draw_x_q;
    draw_y_d      = draw_y_q;
    draw_health_d = draw_health_q;
    left_d        = left_q;

    unique case (state_q)
      // Look at the incoming capture too so a hit to an idle FSM reaches WR in 4 cycles.
      ST_IDLE: if (p1_d.valid || p2_d.valid) state_d = ST_SEL;
      ST_SEL: begin
        if (p1_q.valid) begin
          mem_addr_d = p1_q.addr;
          cur_x_d    = p1_q.bx;
          cur_y_d    = p1_q.by;
          state_d    = ST_RD;
        end else if (p2_q.valid) begin
          mem_addr_d = p2_q.addr;
          cur_x_d    = p2_q.bx;
          cur_y_d    = p2_q.by;
          state_d    = ST_RD;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_RD: state_d = ST_RDW;
      ST_RDW: begin
        // Only h-1 is kept; h == 1 is later recognised as a zero write value.
        mem_wdata_d = mem_rdata - 2'd1;
        if (mem_rdata == HEALTH_DEAD) state_d = ST_IDLE;
        else                          state_d = ST_WR;
      end
      ST_WR: begin
        draw_x_d      = cur_x_q;
        draw_y_d      = cur_y_q;
        draw_health_d = mem_wdata_q;
        if ((mem_wdata_q == HEALTH_DEAD) && (left_q != '0)) left_d = left_q - 8'd1;
        state_d       = ST_DRAW;
      end
      ST_DRAW: if (draw_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      p1_q          <= '0;
      p2_q          <= '0;
      drop_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_health_q <= '0;
      left_q        <= 8'(LEFT_INIT);
    end else begin
      state_q       <= state_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      drop_q        <= drop_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      draw_health_q <= draw_health_d;
      left_q        <= left_d;
    end
  end

  // Strobes decode the state; reset masks them in the cycle it is asserted.
  always_comb begin
    mem_we      = (state_q == ST_WR) && !reset;
    score_inc   = (state_q == ST_WR) && (mem_wdata_q == HEALTH_DEAD) && !reset;
    draw_req    = (state_q == ST_DRAW) && !reset;
    busy        = (state_q != ST_IDLE);
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    draw_x      = draw_x_q;
    draw_y      = draw_y_q;
    draw_health = draw_health_q;
    bricks_left = left_q;
    level_clear = (left_q == '0);
    drop_err    = drop_q;
  end

endmodule

// File: tb/tb_brick_damage.sv
// Self-checking bench for brick_damage: table of single hits plus hand-written
// sequences for simultaneous hits, pending overflow, saturation and reset mid-RMW.
module tb_brick_damage;

  logic       clk = 1'b0;
  logic       reset;
  logic       collided_1, collided_2;
  logic [9:0] col_x1, col_y1, col_x2, col_y2;
  logic [7:0] mem_addr;
  logic [1:0] mem_rdata;
  logic [1:0] mem_wdata;
  logic       mem_we;
  logic       draw_req, draw_ack;
  logic [9:0] draw_x, draw_y;
  logic [1:0] draw_health;
  logic       score_inc;
  logic [7:0] bricks_left;
  logic       level_clear, busy, drop_err;

  always #5 clk = ~clk;

  brick_damage #(.BRICKX(32), .BRICKY(16), .COLS(20), .ROWS(8)) dut (
    .clk(clk), .reset(reset),
    .collided_1(collided_1), .col_x1(col_x1), .col_y1(col_y1),
    .collided_2(collided_2), .col_x2(col_x2), .col_y2(col_y2),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .draw_req(draw_req), .draw_ack(draw_ack),
    .draw_x(draw_x), .draw_y(draw_y), .draw_health(draw_health),
    .score_inc(score_inc), .bricks_left(bricks_left), .level_clear(level_clear),
    .busy(busy), .drop_err(drop_err)
  );

  // Health RAM model: synchronous read, 1-cycle latency; bench preload port.
  logic [1:0] ram [256];
  logic       pl_en;
  logic [7:0] pl_a;
  logic [1:0] pl_v;

  always @(posedge clk) begin
    if (pl_en)       ram[pl_a]     <= pl_v;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int errors = 0;
  int checks = 0;
  int exp_left;

  typedef struct {
    int ch; int x; int y; int init;
    int wr; int addr; int wdata; int bx; int by; int sc;
  } vec_t;
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic set_ram(input int a, input int v);
    pl_en = 1'b1; pl_a = 8'(a); pl_v = 2'(v);
    tick();
    pl_en = 1'b0;
  endtask

  task automatic pulse(input bit c1, input int x1, input int y1,
                       input bit c2, input int x2, input int y2);
    collided_1 = c1; col_x1 = 10'(x1); col_y1 = 10'(y1);
    collided_2 = c2; col_x2 = 10'(x2); col_y2 = 10'(y2);
    tick();
    collided_1 = 1'b0; collided_2 = 1'b0;
  endtask

  task automatic wait_we(input string name, output int k);
    k = 0;
    while (!mem_we && k < 20) begin tick(); k++; end
    chk({name, ".we_seen"}, int'(mem_we), 1);
  endtask

  task automatic ack_draw();
    draw_ack = 1'b1;
    tick();
    draw_ack = 1'b0;
  endtask

  task automatic count_we(input string name, input int cycles);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mem_we) n++;
    end
    chk({name, ".no_write"}, n, 0);
  endtask

  task automatic run_hit(input int ch, input int x, input int y, input int wr,
                         input int addr, input int wdata, input int bx, input int by,
                         input int sc, input string tag);
    int k;
    pulse(ch == 1, x, y, ch == 2, x, y);
    k = 1;
    while (!mem_we && k < 12) begin tick(); k++; end
    chk({tag, ".we"}, int'(mem_we), wr);
    if (wr != 0) begin
      chk({tag, ".latency"}, k, 4);
      chk({tag, ".addr"}, int'(mem_addr), addr);
      chk({tag, ".wdata"}, int'(mem_wdata), wdata);
      chk({tag, ".score"}, int'(score_inc), sc);
      if (sc != 0 && exp_left > 0) exp_left--;
      tick();
      chk({tag, ".score_off"}, int'(score_inc), 0);
      chk({tag, ".we_off"}, int'(mem_we), 0);
      chk({tag, ".req"}, int'(draw_req), 1);
      chk({tag, ".dx"}, int'(draw_x), bx);
      chk({tag, ".dy"}, int'(draw_y), by);
      chk({tag, ".dh"}, int'(draw_health), wdata);
      chk({tag, ".left"}, int'(bricks_left), exp_left);
      chk({tag, ".clear"}, int'(level_clear), int'(exp_left == 0));
      tick(); tick();
      chk({tag, ".req_hold"}, int'(draw_req), 1);
      chk({tag, ".dx_hold"}, int'(draw_x), bx);
      ack_draw();
      chk({tag, ".req_drop"}, int'(draw_req), 0);
      chk({tag, ".idle"}, int'(busy), 0);
      chk({tag, ".ram"}, int'(ram[addr]), wdata);
    end else begin
      chk({tag, ".no_req"}, int'(draw_req), 0);
      chk({tag, ".idle"}, int'(busy), 0);
      chk({tag, ".no_drop"}, int'(drop_err), 0);
      chk({tag, ".left"}, int'(bricks_left), exp_left);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; collided_1 = 1'b0; collided_2 = 1'b0;
    col_x1 = '0; col_y1 = '0; col_x2 = '0; col_y2 = '0;
    draw_ack = 1'b0; pl_en = 1'b0; pl_a = '0; pl_v = '0;
    for (int i = 0; i < 256; i++) set_ram(i, 0);
    tick(); tick();
    reset = 1'b0;

    chk("rst.left", int'(bricks_left), 160);
    chk("rst.clear", int'(level_clear), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.we", int'(mem_we), 0);
    chk("rst.req", int'(draw_req), 0);
    chk("rst.drop", int'(drop_err), 0);
    chk("rst.addr", int'(mem_addr), 0);
    chk("rst.dx", int'(draw_x), 0);
    chk("rst.dh", int'(draw_health), 0);
    exp_left = 160;

    //          ch  x    y    init wr addr wd  bx   by  sc
    vecs[0] = '{1, 160,  32,  3,  1, 45,  2, 160,  32, 0};
    vecs[1] = '{1,   5,   5,  1,  1,  0,  0,   0,   0, 1};
    vecs[2] = '{1,   5,   5,  0,  0,  0,  0,   0,   0, 0};
    vecs[3] = '{2, 639, 127,  2,  1, 159, 1, 608, 112, 0};
    vecs[4] = '{2, 100,  50,  3,  1, 63,  2,  96,  48, 0};
    vecs[5] = '{1, 640,   0, -1,  0,  0,  0,   0,   0, 0};
    vecs[6] = '{1,   0, 200, -1,  0,  0,  0,   0,   0, 0};
    vecs[7] = '{2, 1023, 1023, -1, 0, 0,  0,   0,   0, 0};
    vecs[8] = '{2,  31,  15,  1,  1,  0,  0,   0,   0, 1};
    vecs[9] = '{1, 639, 128, -1,  0,  0,  0,   0,   0, 0};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].init >= 0) set_ram(vecs[i].addr, vecs[i].init);
      run_hit(vecs[i].ch, vecs[i].x, vecs[i].y, vecs[i].wr, vecs[i].addr,
              vecs[i].wdata, vecs[i].bx, vecs[i].by, vecs[i].sc,
              $sformatf("vec%0d", i));
    end

    // Simultaneous hits on different bricks: channel 1 (21) first, then 22.
    set_ram(21, 3); set_ram(22, 2);
    pulse(1'b1, 32, 16, 1'b1, 64, 16);
    wait_we("sim1", k);
    chk("sim1.addr", int'(mem_addr), 21);
    chk("sim1.wdata", int'(mem_wdata), 2);
    tick(); ack_draw();
    wait_we("sim2", k);
    chk("sim2.addr", int'(mem_addr), 22);
    chk("sim2.wdata", int'(mem_wdata), 1);
    tick();
    chk("sim2.dx", int'(draw_x), 64);
    chk("sim2.dy", int'(draw_y), 16);
    ack_draw();
    count_we("sim2", 10);

    // Same brick on both channels: a single decrement, not a drop.
    set_ram(21, 1);
    pulse(1'b1, 40, 20, 1'b1, 33, 17);
    wait_we("same", k);
    chk("same.addr", int'(mem_addr), 21);
    chk("same.score", int'(score_inc), 1);
    exp_left--;
    tick(); ack_draw();
    count_we("same", 15);
    chk("same.left", int'(bricks_left), exp_left);
    chk("same.drop", int'(drop_err), 0);

    // Overflow on channel 1 while the redraw is stalled.
    set_ram(45, 3); set_ram(46, 3); set_ram(47, 3);
    pulse(1'b1, 160, 32, 1'b0, 0, 0);
    k = 0;
    while (!draw_req && k < 20) begin tick(); k++; end
    chk("ovf.first_req", int'(draw_req), 1);
    pulse(1'b1, 192, 32, 1'b0, 0, 0);
    chk("ovf.second_ok", int'(drop_err), 0);
    pulse(1'b1, 0, 200, 1'b0, 0, 0);
    chk("ovf.oob_no_err", int'(drop_err), 0);
    pulse(1'b1, 224, 32, 1'b0, 0, 0);
    chk("ovf.third_drop", int'(drop_err), 1);
    chk("ovf.req_hold", int'(draw_req), 1);
    chk("ovf.dx_hold", int'(draw_x), 160);
    ack_draw();
    wait_we("ovf2", k);
    chk("ovf2.addr", int'(mem_addr), 46);
    chk("ovf2.wdata", int'(mem_wdata), 2);
    tick(); ack_draw();
    count_we("ovf3", 15);
    chk("ovf.ram45", int'(ram[45]), 2);
    chk("ovf.ram47", int'(ram[47]), 3);
    chk("ovf.sticky", int'(drop_err), 1);

    // Destroy every brick, then one more kill at zero to check saturation.
    for (int a = 0; a < 160; a++) begin
      set_ram(a, 1);
      run_hit(1, (a % 20) * 32 + 3, (a / 20) * 16 + 2, 1, a, 0,
              (a % 20) * 32, (a / 20) * 16, 1, $sformatf("kill%0d", a));
    end
    chk("all.left", int'(bricks_left), 0);
    chk("all.clear", int'(level_clear), 1);
    set_ram(0, 1);
    run_hit(1, 0, 0, 1, 0, 0, 0, 0, 1, "sat");
    chk("sat.left", int'(bricks_left), 0);

    // Reset while in RDW: the write must never happen.
    set_ram(100, 3);
    pulse(1'b1, 0, 80, 1'b0, 0, 0);
    tick(); tick();
    chk("rrdw.busy_before", int'(busy), 1);
    reset = 1'b1;
    tick();
    chk("rrdw.busy", int'(busy), 0);
    chk("rrdw.we", int'(mem_we), 0);
    reset = 1'b0;
    count_we("rrdw", 10);
    chk("rrdw.left", int'(bricks_left), 160);
    chk("rrdw.clear", int'(level_clear), 0);
    chk("rrdw.drop", int'(drop_err), 0);
    chk("rrdw.ram", int'(ram[100]), 3);
    chk("rrdw.req", int'(draw_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
